// File: rtl/decode_pipe_pkg.sv
// Shared decode definitions: RV32 opcodes, ALU operand selects, privilege
// modes and the registered decode-output bundle.
package decode_pipe_pkg;

   localparam int XLEN      = 32;
   localparam int REG_IDX_W = 5;

   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

   localparam logic [11:0] MRET_IMM = 12'h302;

   localparam logic [3:0] ALU_OP1_RS1  = 4'b0001;
   localparam logic [3:0] ALU_OP1_PC   = 4'b0010;
   localparam logic [3:0] ALU_OP1_ZERO = 4'b0100;
   localparam logic [3:0] ALU_OP2_RS2  = 4'b0001;
   localparam logic [3:0] ALU_OP2_IMM  = 4'b0010;

   typedef enum logic {
      MODE_USER    = 1'b0,
      MODE_MACHINE = 1'b1
   } mode_e;

   typedef struct packed {
      logic                 valid;
      logic [XLEN-1:0]      pc_pipe;
      logic [XLEN-1:0]      instr;
      logic [XLEN-1:0]      rs1;
      logic [XLEN-1:0]      rs2;
      logic [XLEN-1:0]      imm;
      logic [REG_IDX_W-1:0] rd_ptr;
      logic [7:0]           func3i;
      logic [6:0]           funct7;
      logic [3:0]           op1_sel;
      logic [3:0]           op2_sel;
      logic [1:0]           hb;
      logic                 reg_we;
      logic                 mem_we;
      logic                 mem_re;
      logic                 uload;
      logic                 csr;
      logic                 illegal;
   } dec_out_t;

   function automatic dec_out_t reset_out();
      dec_out_t r;
      r        = '0;
      r.func3i = 8'h01;
      return r;
   endfunction

   // A bubble keeps the data fields but must never enable any side effect.
   function automatic dec_out_t bubble(input dec_out_t o);
      dec_out_t r;
      r         = o;
      r.valid   = 1'b0;
      r.reg_we  = 1'b0;
      r.mem_we  = 1'b0;
      r.mem_re  = 1'b0;
      r.csr     = 1'b0;
      r.illegal = 1'b0;
      return r;
   endfunction

endpackage

// File: rtl/decode_pipe_regfile.sv
// Integer register file: two asynchronous read ports, one synchronous write
// port; x0 and indices beyond NUM_REGS read as zero and ignore writes.
module regfile_p
   import decode_pipe_pkg::*;
#(
   parameter int NUM_REGS = 32
) (
   input  logic                 i_CLK,
   input  logic                 i_WE,
   input  logic [REG_IDX_W-1:0] i_WADDR,
   input  logic [XLEN-1:0]      i_WDATA,
   input  logic [REG_IDX_W-1:0] i_RADDR1,
   input  logic [REG_IDX_W-1:0] i_RADDR2,
   output logic [XLEN-1:0]      o_RDATA1,
   output logic [XLEN-1:0]      o_RDATA2
);

   localparam int AW = $clog2(NUM_REGS);
   localparam logic [REG_IDX_W:0] LIMIT = (REG_IDX_W + 1)'(NUM_REGS);

   logic [XLEN-1:0] regs_q [NUM_REGS];

   function automatic logic is_real_reg(input logic [REG_IDX_W-1:0] a);
      return (a != '0) && ({1'b0, a} < LIMIT);
   endfunction

   always_ff @(posedge i_CLK) begin
      if (i_WE && is_real_reg(i_WADDR)) begin
         regs_q[i_WADDR[AW-1:0]] <= i_WDATA;
      end
   end

   assign o_RDATA1 = is_real_reg(i_RADDR1) ? regs_q[i_RADDR1[AW-1:0]] : '0;
   assign o_RDATA2 = is_real_reg(i_RADDR2) ? regs_q[i_RADDR2[AW-1:0]] : '0;

endmodule

// File: rtl/decode_pipe.sv
// Single-stage RV32 decode: owns the PC and privilege mode, reads/forwards
// operands and registers the decoded bundle behind a valid/ready handshake.
module decode_pipe
   import decode_pipe_pkg::*;
#(
   parameter int          NUM_REGS     = 32,
   parameter logic [31:0] RESET_PC     = 32'h0,
   parameter int          VECTORED_IRQ = 0,
   parameter int          BYPASS       = 1
) (
   input  logic        i_CLK,
   input  logic        i_RSTn,
   input  logic [31:0] i_INSTRUCTION,
   input  logic        i_VALID,
   output logic        o_READY,
   input  logic [31:0] i_RD,
   input  logic [4:0]  i_RD_PTR,
   input  logic        i_REG_WE,
   input  logic        i_IRQ,
   input  logic [3:0]  i_IRQ_CAUSE,
   input  logic [31:0] i_HANDLER_BASE,
   input  logic [31:0] i_MEPC,
   output logic        o_VALID,
   input  logic        i_READY,
   output logic [31:0] o_PC,
   output logic [31:0] o_PC_PIPELINE,
   output logic [31:0] o_INSTRUCTION,
   output logic [31:0] o_RS1,
   output logic [31:0] o_RS2,
   output logic [31:0] o_IMM,
   output logic [4:0]  o_RD_PTR,
   output logic [7:0]  o_FUNC3I,
   output logic [6:0]  o_FUNCT7,
   output logic [3:0]  o_ALU_OP1_SEL,
   output logic [3:0]  o_ALU_OP2_SEL,
   output logic [1:0]  o_HB,
   output logic        o_REG_WE,
   output logic        o_MEM_WE,
   output logic        o_MEM_RE,
   output logic        o_ULOAD,
   output logic        o_CSR,
   output logic        o_ILLEGAL,
   output logic        o_MODE
);

   localparam logic [5:0] REG_LIMIT = 6'(NUM_REGS);

   logic [31:0] pc_q, pc_d;
   mode_e       mode_q, mode_d;
   dec_out_t    out_q, out_d, dec;

   logic [6:0]  opcode;
   logic [4:0]  rd, rs1, rs2;
   logic [2:0]  f3;
   logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;

   assign opcode = i_INSTRUCTION[6:0];
   assign rd     = i_INSTRUCTION[11:7];
   assign f3     = i_INSTRUCTION[14:12];
   assign rs1    = i_INSTRUCTION[19:15];
   assign rs2    = i_INSTRUCTION[24:20];

   assign imm_i = {{20{i_INSTRUCTION[31]}}, i_INSTRUCTION[31:20]};
   assign imm_s = {{20{i_INSTRUCTION[31]}}, i_INSTRUCTION[31:25], i_INSTRUCTION[11:7]};
   assign imm_b = {{19{i_INSTRUCTION[31]}}, i_INSTRUCTION[31], i_INSTRUCTION[7],
                   i_INSTRUCTION[30:25], i_INSTRUCTION[11:8], 1'b0};
   assign imm_u = {i_INSTRUCTION[31:12], 12'b0};
   assign imm_j = {{11{i_INSTRUCTION[31]}}, i_INSTRUCTION[31], i_INSTRUCTION[19:12],
                   i_INSTRUCTION[20], i_INSTRUCTION[30:21], 1'b0};

   logic [31:0] rf_rs1, rf_rs2, rs1_val, rs2_val;

   regfile_p #(
      .NUM_REGS (NUM_REGS)
   ) u_regfile (
      .i_CLK    (i_CLK),
      .i_WE     (i_REG_WE),
      .i_WADDR  (i_RD_PTR),
      .i_WDATA  (i_RD),
      .i_RADDR1 (rs1),
      .i_RADDR2 (rs2),
      .o_RDATA1 (rf_rs1),
      .o_RDATA2 (rf_rs2)
   );

   // A same-cycle writeback would otherwise only land in the array next edge.
   assign rs1_val = ((BYPASS != 0) && i_REG_WE && (i_RD_PTR == rs1) && (rs1 != 5'd0))
                    ? i_RD : rf_rs1;
   assign rs2_val = ((BYPASS != 0) && i_REG_WE && (i_RD_PTR == rs2) && (rs2 != 5'd0))
                    ? i_RD : rf_rs2;

   logic        known, uses_rs1, uses_rs2, uses_rd;
   logic        is_load, is_store, is_alu, is_csr, is_mret, illegal;
   logic [31:0] dec_imm;
   logic [3:0]  op1_sel, op2_sel;

   always_comb begin
      known    = 1'b1;
      uses_rs1 = 1'b0;
      uses_rs2 = 1'b0;
      uses_rd  = 1'b0;
      is_load  = 1'b0;
      is_store = 1'b0;
      is_alu   = 1'b0;
      is_csr   = 1'b0;
      is_mret  = 1'b0;
      dec_imm  = imm_i;
      op1_sel  = ALU_OP1_RS1;
      op2_sel  = ALU_OP2_IMM;
      case (opcode)
         OPC_LUI:    begin uses_rd = 1'b1; dec_imm = imm_u; op1_sel = ALU_OP1_ZERO; end
         OPC_AUIPC:  begin uses_rd = 1'b1; dec_imm = imm_u; op1_sel = ALU_OP1_PC; end
         OPC_JAL:    begin uses_rd = 1'b1; dec_imm = 32'd4; op1_sel = ALU_OP1_PC; end
         OPC_JALR:   begin
            uses_rd  = 1'b1;
            uses_rs1 = 1'b1;
            dec_imm  = 32'd4;
            op1_sel  = ALU_OP1_PC;
         end
         OPC_BRANCH: begin uses_rs1 = 1'b1; uses_rs2 = 1'b1; op2_sel = ALU_OP2_RS2; end
         OPC_LOAD:   begin uses_rd = 1'b1; uses_rs1 = 1'b1; is_load = 1'b1; end
         OPC_STORE:  begin
            uses_rs1 = 1'b1;
            uses_rs2 = 1'b1;
            is_store = 1'b1;
            dec_imm  = imm_s;
         end
         OPC_OPIMM:  begin uses_rd = 1'b1; uses_rs1 = 1'b1; is_alu = 1'b1; end
         OPC_OP:     begin
            uses_rd  = 1'b1;
            uses_rs1 = 1'b1;
            uses_rs2 = 1'b1;
            is_alu   = 1'b1;
            op2_sel  = ALU_OP2_RS2;
         end
         OPC_SYSTEM: begin
            dec_imm = {20'b0, i_INSTRUCTION[31:20]};
            if (f3 == 3'b000) begin
               is_mret = (i_INSTRUCTION[31:20] == MRET_IMM);
            end else begin
               is_csr   = 1'b1;
               uses_rd  = 1'b1;
               uses_rs1 = ~f3[2];
            end
         end
         default: known = 1'b0;
      endcase
   end

   // Only fields the format actually uses can make an index illegal.
   assign illegal = ~known
                  | (uses_rd  & ({1'b0, rd}  >= REG_LIMIT))
                  | (uses_rs1 & ({1'b0, rs1} >= REG_LIMIT))
                  | (uses_rs2 & ({1'b0, rs2} >= REG_LIMIT));

   logic taken;

   always_comb begin
      taken = 1'b0;
      case (f3)
         3'b000:  taken = (rs1_val == rs2_val);
         3'b001:  taken = (rs1_val != rs2_val);
         3'b100:  taken = ($signed(rs1_val) <  $signed(rs2_val));
         3'b101:  taken = ($signed(rs1_val) >= $signed(rs2_val));
         3'b110:  taken = (rs1_val <  rs2_val);
         3'b111:  taken = (rs1_val >= rs2_val);
         default: taken = 1'b0;
      endcase
   end

   logic [31:0] next_pc;

   always_comb begin
      next_pc = pc_q + 32'd4;
      if (!illegal) begin
         if (is_mret) begin
            next_pc = i_MEPC;
         end else if (opcode == OPC_JALR) begin
            next_pc = (rs1_val + imm_i) & ~32'h1;
         end else if (opcode == OPC_JAL) begin
            next_pc = pc_q + imm_j;
         end else if ((opcode == OPC_BRANCH) && taken) begin
            next_pc = pc_q + imm_b;
         end
      end
   end

   always_comb begin
      dec         = reset_out();
      dec.valid   = 1'b1;
      dec.pc_pipe = pc_q;
      dec.instr   = i_INSTRUCTION;
      dec.rs1     = rs1_val;
      dec.rs2     = rs2_val;
      dec.imm     = dec_imm;
      dec.rd_ptr  = rd;
      dec.funct7  = i_INSTRUCTION[31:25];
      dec.op1_sel = op1_sel;
      dec.op2_sel = op2_sel;
      dec.hb      = f3[1:0];
      dec.uload   = f3[2];
      if (is_alu) begin
         dec.func3i = 8'b1 << f3;
      end
      if (illegal) begin
         dec.illegal = 1'b1;
      end else begin
         dec.reg_we = uses_rd;
         dec.mem_we = is_store;
         dec.mem_re = is_load;
         dec.csr    = is_csr;
      end
   end

   logic hazard, irq_take, down_free, accept;
   logic [31:0] irq_target;

   assign hazard = out_q.valid & out_q.mem_re & (out_q.rd_ptr != 5'd0)
                 & ((uses_rs1 & (rs1 == out_q.rd_ptr)) | (uses_rs2 & (rs2 == out_q.rd_ptr)));
   assign irq_take   = i_IRQ & (mode_q == MODE_USER);
   assign down_free  = ~out_q.valid | i_READY;
   assign o_READY    = down_free & ~hazard & ~irq_take;
   assign accept     = i_VALID & o_READY;
   assign irq_target = (VECTORED_IRQ != 0)
                       ? i_HANDLER_BASE + {26'b0, i_IRQ_CAUSE, 2'b00}
                       : i_HANDLER_BASE;

   // A stalled output is never overwritten, even by an interrupt bubble.
   always_comb begin
      pc_d   = pc_q;
      mode_d = mode_q;
      out_d  = out_q;
      if (irq_take) begin
         pc_d   = irq_target;
         mode_d = MODE_MACHINE;
         if (down_free) begin
            out_d = bubble(out_q);
         end
      end else if (accept) begin
         pc_d  = next_pc;
         out_d = dec;
         if (is_mret && !illegal) begin
            mode_d = MODE_USER;
         end
      end else if (down_free) begin
         out_d = bubble(out_q);
      end
   end

   always_ff @(posedge i_CLK) begin
      if (!i_RSTn) begin
         pc_q   <= RESET_PC;
         mode_q <= MODE_USER;
         out_q  <= reset_out();
      end else begin
         pc_q   <= pc_d;
         mode_q <= mode_d;
         out_q  <= out_d;
      end
   end

   assign o_VALID       = out_q.valid;
   assign o_PC          = pc_q;
   assign o_PC_PIPELINE = out_q.pc_pipe;
   assign o_INSTRUCTION = out_q.instr;
   assign o_RS1         = out_q.rs1;
   assign o_RS2         = out_q.rs2;
   assign o_IMM         = out_q.imm;
   assign o_RD_PTR      = out_q.rd_ptr;
   assign o_FUNC3I      = out_q.func3i;
   assign o_FUNCT7      = out_q.funct7;
   assign o_ALU_OP1_SEL = out_q.op1_sel;
   assign o_ALU_OP2_SEL = out_q.op2_sel;
   assign o_HB          = out_q.hb;
   assign o_REG_WE      = out_q.reg_we;
   assign o_MEM_WE      = out_q.mem_we;
   assign o_MEM_RE      = out_q.mem_re;
   assign o_ULOAD       = out_q.uload;
   assign o_CSR         = out_q.csr;
   assign o_ILLEGAL     = out_q.illegal;
   assign o_MODE        = mode_q;

endmodule

// File: tb/tb_decode_pipe.sv
// Directed bench for decode_pipe: instance A (vectored IRQ, 32 regs) runs the
// main sequence, instance B (16 regs) shares stimulus for the RV32E check.
module tb_decode_pipe;

   logic        i_CLK = 1'b0;
   logic        i_RSTn;
   logic [31:0] i_INSTRUCTION;
   logic        i_VALID;
   logic [31:0] i_RD;
   logic [4:0]  i_RD_PTR;
   logic        i_REG_WE;
   logic        i_IRQ;
   logic [3:0]  i_IRQ_CAUSE;
   logic [31:0] i_HANDLER_BASE;
   logic [31:0] i_MEPC;
   logic        i_READY;

   logic        o_READY, o_VALID;
   logic [31:0] o_PC, o_PC_PIPELINE, o_INSTRUCTION, o_RS1, o_RS2, o_IMM;
   logic [4:0]  o_RD_PTR;
   logic [7:0]  o_FUNC3I;
   logic [6:0]  o_FUNCT7;
   logic [3:0]  o_ALU_OP1_SEL, o_ALU_OP2_SEL;
   logic [1:0]  o_HB;
   logic        o_REG_WE, o_MEM_WE, o_MEM_RE, o_ULOAD, o_CSR, o_ILLEGAL, o_MODE;

   logic        b_READY, b_VALID;
   logic [31:0] b_PC, b_PC_PIPELINE, b_INSTRUCTION, b_RS1, b_RS2, b_IMM;
   logic [4:0]  b_RD_PTR;
   logic [7:0]  b_FUNC3I;
   logic [6:0]  b_FUNCT7;
   logic [3:0]  b_ALU_OP1_SEL, b_ALU_OP2_SEL;
   logic [1:0]  b_HB;
   logic        b_REG_WE, b_MEM_WE, b_MEM_RE, b_ULOAD, b_CSR, b_ILLEGAL, b_MODE;

   int total = 0;
   int bad   = 0;

   always #5 i_CLK = ~i_CLK;

   decode_pipe #(
      .NUM_REGS(32), .RESET_PC(32'h0), .VECTORED_IRQ(1), .BYPASS(1)
   ) dut_a (
      .i_CLK(i_CLK), .i_RSTn(i_RSTn), .i_INSTRUCTION(i_INSTRUCTION), .i_VALID(i_VALID),
      .o_READY(o_READY), .i_RD(i_RD), .i_RD_PTR(i_RD_PTR), .i_REG_WE(i_REG_WE),
      .i_IRQ(i_IRQ), .i_IRQ_CAUSE(i_IRQ_CAUSE), .i_HANDLER_BASE(i_HANDLER_BASE),
      .i_MEPC(i_MEPC), .o_VALID(o_VALID), .i_READY(i_READY), .o_PC(o_PC),
      .o_PC_PIPELINE(o_PC_PIPELINE), .o_INSTRUCTION(o_INSTRUCTION), .o_RS1(o_RS1),
      .o_RS2(o_RS2), .o_IMM(o_IMM), .o_RD_PTR(o_RD_PTR), .o_FUNC3I(o_FUNC3I),
      .o_FUNCT7(o_FUNCT7), .o_ALU_OP1_SEL(o_ALU_OP1_SEL), .o_ALU_OP2_SEL(o_ALU_OP2_SEL),
      .o_HB(o_HB), .o_REG_WE(o_REG_WE), .o_MEM_WE(o_MEM_WE), .o_MEM_RE(o_MEM_RE),
      .o_ULOAD(o_ULOAD), .o_CSR(o_CSR), .o_ILLEGAL(o_ILLEGAL), .o_MODE(o_MODE)
   );

   decode_pipe #(
      .NUM_REGS(16), .RESET_PC(32'h0), .VECTORED_IRQ(0), .BYPASS(1)
   ) dut_b (
      .i_CLK(i_CLK), .i_RSTn(i_RSTn), .i_INSTRUCTION(i_INSTRUCTION), .i_VALID(i_VALID),
      .o_READY(b_READY), .i_RD(i_RD), .i_RD_PTR(i_RD_PTR), .i_REG_WE(i_REG_WE),
      .i_IRQ(i_IRQ), .i_IRQ_CAUSE(i_IRQ_CAUSE), .i_HANDLER_BASE(i_HANDLER_BASE),
      .i_MEPC(i_MEPC), .o_VALID(b_VALID), .i_READY(i_READY), .o_PC(b_PC),
      .o_PC_PIPELINE(b_PC_PIPELINE), .o_INSTRUCTION(b_INSTRUCTION), .o_RS1(b_RS1),
      .o_RS2(b_RS2), .o_IMM(b_IMM), .o_RD_PTR(b_RD_PTR), .o_FUNC3I(b_FUNC3I),
      .o_FUNCT7(b_FUNCT7), .o_ALU_OP1_SEL(b_ALU_OP1_SEL), .o_ALU_OP2_SEL(b_ALU_OP2_SEL),
      .o_HB(b_HB), .o_REG_WE(b_REG_WE), .o_MEM_WE(b_MEM_WE), .o_MEM_RE(b_MEM_RE),
      .o_ULOAD(b_ULOAD), .o_CSR(b_CSR), .o_ILLEGAL(b_ILLEGAL), .o_MODE(b_MODE)
   );

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge i_CLK);
      #1;
   endtask

   task automatic applyStimulus(input logic [31:0] instr, input logic valid, input logic ready);
      i_INSTRUCTION = instr;
      i_VALID       = valid;
      i_READY       = ready;
      #1;
   endtask

   task automatic writeReg(input logic [4:0] ptr, input logic [31:0] data);
      i_VALID  = 1'b0;
      i_REG_WE = 1'b1;
      i_RD_PTR = ptr;
      i_RD     = data;
      tick();
      i_REG_WE = 1'b0;
   endtask

   initial begin
      i_RSTn = 1'b0; i_INSTRUCTION = '0; i_VALID = 1'b1; i_READY = 1'b1;
      i_RD = '0; i_RD_PTR = '0; i_REG_WE = 1'b0;
      i_IRQ = 1'b1; i_IRQ_CAUSE = 4'd3; i_HANDLER_BASE = 32'h100; i_MEPC = 32'h40;
      tick();
      tick();
      checkOutput("reset_valid", o_VALID, 0);
      checkOutput("reset_pc", o_PC, 32'h0);
      checkOutput("reset_mode", o_MODE, 0);
      checkOutput("reset_func3i", o_FUNC3I, 32'h01);
      checkOutput("reset_imm", o_IMM, 0);
      checkOutput("reset_regwe", o_REG_WE, 0);
      i_RSTn = 1'b1;
      i_IRQ  = 1'b0;

      // ADDI x1,x0,5
      applyStimulus(32'h00500093, 1'b1, 1'b1);
      checkOutput("addi_ready", o_READY, 1);
      tick();
      checkOutput("addi_valid", o_VALID, 1);
      checkOutput("addi_imm", o_IMM, 5);
      checkOutput("addi_regwe", o_REG_WE, 1);
      checkOutput("addi_pc", o_PC, 32'h4);
      checkOutput("addi_rdptr", o_RD_PTR, 1);
      checkOutput("addi_pcpipe", o_PC_PIPELINE, 32'h0);
      checkOutput("addi_op2sel", o_ALU_OP2_SEL, 4'b0010);

      // LW x2,0(x1) then ADD x3,x2,x2 load-use
      applyStimulus(32'h0000A103, 1'b1, 1'b1);
      tick();
      checkOutput("lw_memre", o_MEM_RE, 1);
      checkOutput("lw_hb", o_HB, 2);
      checkOutput("lw_pc", o_PC, 32'h8);
      applyStimulus(32'h002101B3, 1'b1, 1'b1);
      checkOutput("hazard_ready", o_READY, 0);
      tick();
      checkOutput("bubble_valid", o_VALID, 0);
      checkOutput("bubble_memre", o_MEM_RE, 0);
      checkOutput("bubble_pc", o_PC, 32'h8);
      checkOutput("after_bubble_ready", o_READY, 1);
      tick();
      checkOutput("add_valid", o_VALID, 1);
      checkOutput("add_instr", o_INSTRUCTION, 32'h002101B3);
      checkOutput("add_pc", o_PC, 32'hC);

      writeReg(5'd1, 32'd7);
      checkOutput("idle_valid_drop", o_VALID, 0);
      writeReg(5'd2, 32'd7);
      writeReg(5'd0, 32'hDEAD);

      // JAL x0,+0x14 from 0xC
      applyStimulus(32'h0140006F, 1'b1, 1'b1);
      tick();
      checkOutput("jal_pc", o_PC, 32'h20);
      checkOutput("jal_imm", o_IMM, 4);
      checkOutput("jal_pcpipe", o_PC_PIPELINE, 32'hC);

      // BEQ x1,x2,-8 with x1=x2=7
      applyStimulus(32'hFE208CE3, 1'b1, 1'b1);
      tick();
      checkOutput("beq_taken_pc", o_PC, 32'h18);
      checkOutput("beq_rs1", o_RS1, 7);
      checkOutput("beq_rs2", o_RS2, 7);
      checkOutput("beq_regwe", o_REG_WE, 0);

      writeReg(5'd2, 32'd8);
      applyStimulus(32'h0080006F, 1'b1, 1'b1);
      tick();
      checkOutput("jal8_pc", o_PC, 32'h20);
      applyStimulus(32'hFE208CE3, 1'b1, 1'b1);
      tick();
      checkOutput("beq_nottaken_pc", o_PC, 32'h24);
      applyStimulus(32'hFE209CE3, 1'b1, 1'b1);
      tick();
      checkOutput("bne_taken_pc", o_PC, 32'h1C);

      writeReg(5'd1, 32'hFFFF_FFFF);
      applyStimulus(32'hFE20CCE3, 1'b1, 1'b1);
      tick();
      checkOutput("blt_signed_pc", o_PC, 32'h14);
      applyStimulus(32'hFE20ECE3, 1'b1, 1'b1);
      tick();
      checkOutput("bltu_unsigned_pc", o_PC, 32'h18);

      // Vectored interrupt while an instruction is pending
      i_IRQ = 1'b1;
      applyStimulus(32'h00500093, 1'b1, 1'b1);
      checkOutput("irq_ready", o_READY, 0);
      tick();
      checkOutput("irq_pc", o_PC, 32'h10C);
      checkOutput("irq_mode", o_MODE, 1);
      checkOutput("irq_valid", o_VALID, 0);

      // MRET while IRQ still high: machine mode ignores it
      applyStimulus(32'h30200073, 1'b1, 1'b1);
      checkOutput("mret_ready", o_READY, 1);
      tick();
      i_IRQ = 1'b0;
      checkOutput("mret_pc", o_PC, 32'h40);
      checkOutput("mret_mode", o_MODE, 0);
      checkOutput("mret_valid", o_VALID, 1);

      // Downstream stall
      applyStimulus(32'h00500093, 1'b1, 1'b1);
      tick();
      applyStimulus(32'h00028333, 1'b1, 1'b0);
      for (int c = 0; c < 3; c++) begin
         checkOutput("stall_ready", o_READY, 0);
         tick();
         checkOutput("stall_valid", o_VALID, 1);
         checkOutput("stall_instr", o_INSTRUCTION, 32'h00500093);
         checkOutput("stall_pc", o_PC, 32'h44);
         checkOutput("stall_imm", o_IMM, 5);
      end

      // ADD x6,x5,x0 with same-cycle writeback of x5
      i_REG_WE = 1'b1; i_RD_PTR = 5'd5; i_RD = 32'hA5;
      applyStimulus(32'h00028333, 1'b1, 1'b1);
      checkOutput("fwd_ready", o_READY, 1);
      tick();
      i_REG_WE = 1'b0;
      checkOutput("fwd_rs1", o_RS1, 32'hA5);
      checkOutput("x0_rs2", o_RS2, 0);
      checkOutput("fwd_pc", o_PC, 32'h48);

      applyStimulus(32'h005283B3, 1'b1, 1'b1);
      tick();
      checkOutput("rf_rs1", o_RS1, 32'hA5);
      checkOutput("rf_rs2", o_RS2, 32'hA5);

      // ORI x1,x0,1 -> funct3 110 one-hot
      applyStimulus(32'h00106093, 1'b1, 1'b1);
      tick();
      checkOutput("ori_func3i", o_FUNC3I, 32'h40);
      checkOutput("ori_pc", o_PC, 32'h50);

      // Reset dominates IRQ and a valid handshake
      i_RSTn = 1'b0;
      i_IRQ  = 1'b1;
      applyStimulus(32'h00500093, 1'b1, 1'b1);
      tick();
      checkOutput("rst_dom_pc", o_PC, 32'h0);
      checkOutput("rst_dom_mode", o_MODE, 0);
      checkOutput("rst_dom_valid", o_VALID, 0);
      i_RSTn = 1'b1;
      i_IRQ  = 1'b0;

      // ADD x20,x1,x2: illegal on 16 registers, legal on 32
      applyStimulus(32'h00208A33, 1'b1, 1'b1);
      tick();
      checkOutput("rv32e_valid", b_VALID, 1);
      checkOutput("rv32e_illegal", b_ILLEGAL, 1);
      checkOutput("rv32e_regwe", b_REG_WE, 0);
      checkOutput("rv32e_pc", b_PC, 32'h4);
      checkOutput("rv32i_illegal", o_ILLEGAL, 0);
      checkOutput("rv32i_regwe", o_REG_WE, 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
